particle_bins_unit: RTL and testbench
=====================================

// Module: particle_bins_unit
// PURPOSE
// - One spatial cell of the MD particle store; holds particles whose position maps to bin (BIN_ID_X,Y,Z).
// - Force phase: random read port for the force pipeline. Motion-update phase: re-bins its particles,
//   emits departing ones with destination bin, absorbs incoming ones addressed to it.
// - Ping-pong banks: force reads hit the active bank while motion update rebuilds the shadow bank.
// PARAMETERS
// BIN_ID_X / BIN_ID_Y / BIN_ID_Z  0    this cell's bin coordinates
// BIN_ADDR_WIDTH    4       width of one bin coordinate
// DATA_WIDTH        160     particle word {Energy,Force,Z,Y,X}, 32 b each, X at [31:0]
// ADDR_WIDTH        7       bank address width
// BIN_DEPTH         128     particles per bank (=2**ADDR_WIDTH)
// BIN_OFFSET_WIDTH  3       log2(cutoff); bin coordinate = pos[BIN_OFFSET_WIDTH+BIN_ADDR_WIDTH-1:BIN_OFFSET_WIDTH]
// PORTS
// clk                               in   1    single clock, rising edge
// rst_n                             in   1    synchronous, active-low reset
// rd_addr                           in   AW   force-phase read address
// evaluation_particle_read_out      out  DW   particle at rd_addr (active bank)
// evaluation_particle_valid         out  1    read_out holds a stored particle
// motion_update_enable              in   1    high for the whole motion update; fall = commit
// incom_particle_data_valid         in   1    incoming particle strobe
// incom_particle_data_target_bin_x/y/z in BAW each  incoming particle's target bin
// incom_particle_data_in            in   DW   incoming particle word
// particle_input_available          out  1    cell can accept an incoming particle this cycle
// particle_output_available         in   1    downstream accepts a departing particle
// particle_data_out                 out  DW   departing particle word
// particle_out_valid                out  1    one-cycle strobe per departing particle
// particle_data_dest_bin_x/y/z      out  BAW each  destination bin of departing particle
// local_motion_update_done          out  1    scan of this cell complete
// BEHAVIOUR
// - Reset: all outputs 0, both counts 0, active bank = 0, FSM IDLE; RAM contents not cleared.
// - Force read: 1-cycle latency; read_out = active[rd_addr] registered; valid = registered (rd_addr < active_count).
// - FSM IDLE->SCAN on rising edge of motion_update_enable (enable & ~prev); clears shadow_count, scan_ptr, done.
// - SCAN: per particle two phases: READ active[scan_ptr]; DISPOSE: compute dest bin from X/Y/Z bits;
//   equal to own ID -> keep: write shadow[shadow_count], shadow_count++; else depart: when
//   particle_output_available=1 register particle_data_out/dest_bin, particle_out_valid=1 for one cycle;
//   when 0 hold DISPOSE. scan_ptr++ after disposal.
// - Incoming: accepted when valid & target==own ID & particle_input_available; written to shadow[shadow_count]
//   same cycle; takes priority over a keep write (keep retries next cycle). Mismatched target or valid=0: ignored.
// - particle_input_available = motion_update_enable & (shadow_count + (active_count - scan_ptr) < BIN_DEPTH);
//   space for unscanned particles is reserved so keeps never overflow; input when unavailable is dropped.
// - SCAN->DONE when scan_ptr == active_count and no departure pending; local_motion_update_done=1, held until enable falls.
// - Enable falling edge (any state): swap banks, active_count <= shadow_count, done <= 0, FSM IDLE.
//   Falling before DONE: swap still occurs, unscanned particles are lost (protocol violation).
// - Empty cell: SCAN->DONE in 1 cycle. Counts are ADDR_WIDTH+1 bits (0..BIN_DEPTH).
// - Enable rising and falling never in same cycle; reset mid-operation returns to reset state, next cycle IDLE.
// STRUCTURE
// - Shared package: field offsets (X/Y/Z/FORCE/ENERGY), bin-coordinate extract function, count width.
// - One sub-module: bin_ram (1 write port, 2 read ports, registered read), instantiated twice (ping-pong).
// - Top: FSM, counters, bank select, incoming arbiter, output register.
// TESTING
// - Reset, rd_addr 0..11 -> evaluation_particle_valid stays 0 (empty cell), all outputs 0.
// - Iter 1: enable high, 6 particles target (0,0,0), X={c,3'b001},Y={c,3'b010},Z={c,3'b011}
//   -> all accepted; done after 1 cycle; after enable falls rd_addr 0..5 valid=1 in arrival order, 6..11 valid=0.
// - Iter 2 on those: particles with c=1..4 -> particle_out_valid pulses, dest bins (1,1,1)..(4,4,4); c=0 and
//   zero word kept; incoming targets 1..5 ignored, target 0 accepted; post-commit count = 3.
// - particle_output_available=0 during departure -> scan stalls, no out_valid, done stays 0 until released.
// - Fill shadow to BIN_DEPTH with incoming -> particle_input_available drops; extra input discarded; count=128.
// - Simultaneous incoming and keep write -> both stored, incoming at lower address; count +2.

Source files
------------

// File: rtl/particle_bins_unit_pkg.sv
// Shared definitions for the particle bin cell: particle word layout,
// counter sizing, FSM encoding and bin-coordinate extraction.
package particle_bins_unit_pkg;

   localparam int FIELD_W    = 32;
   localparam int X_OFF      = 0;
   localparam int Y_OFF      = 32;
   localparam int Z_OFF      = 64;
   localparam int FORCE_OFF  = 96;
   localparam int ENERGY_OFF = 128;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DISP,
      S_DONE
   } state_e;

   // Counts must reach BIN_DEPTH itself, hence one extra bit.
   function automatic int cnt_w(input int aw);
      return aw + 1;
   endfunction

   function automatic logic [31:0] bin_field(input logic [31:0] pos,
                                             input int off_w,
                                             input int addr_w);
      return (pos >> off_w) & ((32'd1 << addr_w) - 32'd1);
   endfunction

endpackage

// File: rtl/particle_bins_unit_bin_ram.sv
// One particle bank: single write port, two registered read ports.
// Only the read registers are reset; storage keeps its contents.
module particle_bins_unit_bin_ram #(
   parameter int DW = 160,
   parameter int AW = 7
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_a_i,
   output logic [DW-1:0] rdata_a_o,
   input  logic [AW-1:0] raddr_b_i,
   output logic [DW-1:0] rdata_b_o
);

   logic [DW-1:0] mem_q [2**AW];
   logic [DW-1:0] rdata_a_q, rdata_b_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rdata_a_q <= '0;
         rdata_b_q <= '0;
      end else begin
         rdata_a_q <= mem_q[raddr_a_i];
         rdata_b_q <= mem_q[raddr_b_i];
      end
   end

   assign rdata_a_o = rdata_a_q;
   assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/particle_bins_unit.sv
// Spatial cell of the MD particle store: force-phase read port plus
// motion-update re-binning over ping-pong banks.
module particle_bins_unit
   import particle_bins_unit_pkg::*;
#(
   parameter int BIN_ID_X         = 0,
   parameter int BIN_ID_Y         = 0,
   parameter int BIN_ID_Z         = 0,
   parameter int BIN_ADDR_WIDTH   = 4,
   parameter int DATA_WIDTH       = 160,
   parameter int ADDR_WIDTH       = 7,
   parameter int BIN_DEPTH        = 128,
   parameter int BIN_OFFSET_WIDTH = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [ADDR_WIDTH-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0]     evaluation_particle_read_out,
   output logic                      evaluation_particle_valid,
   input  logic                      motion_update_enable,
   input  logic                      incom_particle_data_valid,
   input  logic [BIN_ADDR_WIDTH-1:0] incom_particle_data_target_bin_x,
   input  logic [BIN_ADDR_WIDTH-1:0] incom_particle_data_target_bin_y,
   input  logic [BIN_ADDR_WIDTH-1:0] incom_particle_data_target_bin_z,
   input  logic [DATA_WIDTH-1:0]     incom_particle_data_in,
   output logic                      particle_input_available,
   input  logic                      particle_output_available,
   output logic [DATA_WIDTH-1:0]     particle_data_out,
   output logic                      particle_out_valid,
   output logic [BIN_ADDR_WIDTH-1:0] particle_data_dest_bin_x,
   output logic [BIN_ADDR_WIDTH-1:0] particle_data_dest_bin_y,
   output logic [BIN_ADDR_WIDTH-1:0] particle_data_dest_bin_z,
   output logic                      local_motion_update_done
);

   localparam int CW  = cnt_w(ADDR_WIDTH);
   localparam int BAW = BIN_ADDR_WIDTH;
   localparam int BOW = BIN_OFFSET_WIDTH;
   localparam logic [CW-1:0]  DEPTH_C = CW'(BIN_DEPTH);
   localparam logic [BAW-1:0] OWN_X   = BIN_ID_X[BAW-1:0];
   localparam logic [BAW-1:0] OWN_Y   = BIN_ID_Y[BAW-1:0];
   localparam logic [BAW-1:0] OWN_Z   = BIN_ID_Z[BAW-1:0];

   state_e state_q, state_d;
   logic en_q, rise, fall;
   logic act_q, sel_q;
   logic [CW-1:0] act_cnt_q, shd_cnt_q, ptr_q;
   logic [CW-1:0] shd_cnt_d, ptr_d;
   logic [DATA_WIDTH-1:0] ra0, ra1, rb0, rb1, scan_w;
   logic [DATA_WIDTH-1:0] wdata, out_q;
   logic [BAW-1:0] bx, by, bz, dx_q, dy_q, dz_q;
   logic [ADDR_WIDTH-1:0] waddr;
   logic home, inc_acc, keep_wr, depart, wr_en;
   logic ev_valid_q, out_valid_q, done_q;

   assign rise = motion_update_enable & ~en_q;
   assign fall = ~motion_update_enable & en_q;

   assign scan_w = act_q ? rb1 : rb0;
   assign bx = BAW'(bin_field(scan_w[X_OFF +: FIELD_W], BOW, BAW));
   assign by = BAW'(bin_field(scan_w[Y_OFF +: FIELD_W], BOW, BAW));
   assign bz = BAW'(bin_field(scan_w[Z_OFF +: FIELD_W], BOW, BAW));
   assign home = (bx == OWN_X) && (by == OWN_Y) && (bz == OWN_Z);

   // Unscanned particles keep a reserved slot so keeps never overflow.
   assign particle_input_available = motion_update_enable &&
      ((shd_cnt_q + (act_cnt_q - ptr_q)) < DEPTH_C);

   assign inc_acc = incom_particle_data_valid &&
      particle_input_available &&
      (incom_particle_data_target_bin_x == OWN_X) &&
      (incom_particle_data_target_bin_y == OWN_Y) &&
      (incom_particle_data_target_bin_z == OWN_Z);

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (rise) state_d = S_READ;
         S_READ: state_d = (ptr_q == act_cnt_q) ? S_DONE : S_DISP;
         S_DISP: if (keep_wr || depart) state_d = S_READ;
         S_DONE: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
      if (fall) state_d = S_IDLE;
   end

   always_comb begin
      keep_wr = 1'b0;
      depart  = 1'b0;
      if (state_q == S_DISP) begin
         keep_wr = home & ~inc_acc;
         depart  = ~home & particle_output_available;
      end
   end

   assign wr_en = inc_acc | keep_wr;
   assign wdata = inc_acc ? incom_particle_data_in : scan_w;
   assign waddr = rise ? '0 : shd_cnt_q[ADDR_WIDTH-1:0];

   always_comb begin
      shd_cnt_d = shd_cnt_q;
      ptr_d     = ptr_q;
      if (rise) begin
         shd_cnt_d = inc_acc ? CW'(1) : '0;
         ptr_d     = '0;
      end else begin
         if (wr_en)            shd_cnt_d = shd_cnt_q + 1'b1;
         if (keep_wr | depart) ptr_d     = ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         en_q        <= 1'b0;
         act_q       <= 1'b0;
         sel_q       <= 1'b0;
         act_cnt_q   <= '0;
         shd_cnt_q   <= '0;
         ptr_q       <= '0;
         ev_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         dx_q        <= '0;
         dy_q        <= '0;
         dz_q        <= '0;
         done_q      <= 1'b0;
      end else begin
         en_q        <= motion_update_enable;
         sel_q       <= act_q;
         shd_cnt_q   <= shd_cnt_d;
         ptr_q       <= ptr_d;
         ev_valid_q  <= {1'b0, rd_addr} < act_cnt_q;
         out_valid_q <= depart;
         done_q      <= (state_d == S_DONE);
         if (depart) begin
            out_q <= scan_w;
            dx_q  <= bx;
            dy_q  <= by;
            dz_q  <= bz;
         end
         if (fall) begin
            act_q     <= ~act_q;
            act_cnt_q <= shd_cnt_q;
         end
      end
   end

   // Writes always land in the shadow bank (the one not active).
   particle_bins_unit_bin_ram #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_bank0 (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .we_i      (wr_en & act_q),
      .waddr_i   (waddr),
      .wdata_i   (wdata),
      .raddr_a_i (rd_addr),
      .rdata_a_o (ra0),
      .raddr_b_i (ptr_q[ADDR_WIDTH-1:0]),
      .rdata_b_o (rb0)
   );

   particle_bins_unit_bin_ram #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_bank1 (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .we_i      (wr_en & ~act_q),
      .waddr_i   (waddr),
      .wdata_i   (wdata),
      .raddr_a_i (rd_addr),
      .rdata_a_o (ra1),
      .raddr_b_i (ptr_q[ADDR_WIDTH-1:0]),
      .rdata_b_o (rb1)
   );

   assign evaluation_particle_read_out = sel_q ? ra1 : ra0;
   assign evaluation_particle_valid    = ev_valid_q;
   assign particle_data_out            = out_q;
   assign particle_out_valid           = out_valid_q;
   assign particle_data_dest_bin_x     = dx_q;
   assign particle_data_dest_bin_y     = dy_q;
   assign particle_data_dest_bin_z     = dz_q;
   assign local_motion_update_done     = done_q;

endmodule

// File: tb/tb_particle_bins_unit.sv
// Randomized bench for particle_bins_unit against a queue-based model
// of the cell's particle lists.
module tb_particle_bins_unit;

   localparam int DW    = 160;
   localparam int AW    = 7;
   localparam int BAW   = 4;
   localparam int DEPTH = 128;

   typedef logic [DW-1:0] word_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   word_t ev_data;
   logic ev_valid;
   logic en = 1'b0;
   logic in_valid = 1'b0;
   logic [BAW-1:0] tx = '0, ty = '0, tz = '0;
   word_t in_data = '0;
   logic in_avail;
   logic out_avail = 1'b1;
   word_t out_data;
   logic out_valid;
   logic [BAW-1:0] dx, dy, dz;
   logic done;

   always #5 clk = ~clk;

   particle_bins_unit dut (
      .clk                              (clk),
      .rst_n                            (rst_n),
      .rd_addr                          (rd_addr),
      .evaluation_particle_read_out     (ev_data),
      .evaluation_particle_valid        (ev_valid),
      .motion_update_enable             (en),
      .incom_particle_data_valid        (in_valid),
      .incom_particle_data_target_bin_x (tx),
      .incom_particle_data_target_bin_y (ty),
      .incom_particle_data_target_bin_z (tz),
      .incom_particle_data_in           (in_data),
      .particle_input_available         (in_avail),
      .particle_output_available        (out_avail),
      .particle_data_out                (out_data),
      .particle_out_valid               (out_valid),
      .particle_data_dest_bin_x         (dx),
      .particle_data_dest_bin_y         (dy),
      .particle_data_dest_bin_z         (dz),
      .local_motion_update_done         (done)
   );

   int n_checks = 0;
   int n_errors = 0;
   word_t act_m[$];
   word_t shd_m[$];
   word_t dep_q[$];

   task automatic chk(input string tag, input word_t obs, input word_t exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bin coordinate of field f: position divided by cutoff, modulo bins.
   function automatic logic [BAW-1:0] bin_of(input word_t w, input int f);
      logic [31:0] p;
      p = w[f*32 +: 32];
      return BAW'((p / 8) % 16);
   endfunction

   function automatic bit is_home(input word_t w);
      return bin_of(w, 0) == 0 && bin_of(w, 1) == 0 && bin_of(w, 2) == 0;
   endfunction

   function automatic word_t mk_spec(input int c);
      word_t w;
      w = {$urandom, $urandom, 32'(c * 8 + 3), 32'(c * 8 + 2), 32'(c * 8 + 1)};
      return w;
   endfunction

   function automatic word_t mk_rand(input bit home);
      word_t w;
      logic [31:0] p;
      int c;
      w = {$urandom, $urandom, $urandom, $urandom, $urandom};
      for (int f = 0; f < 3; f++) begin
         c = home ? 0 : int'($urandom_range(0, 15));
         p = ($urandom & 32'hFFFF_FF87) | 32'(c * 8);
         w[f*32 +: 32] = p;
      end
      return w;
   endfunction

   task automatic scan(input bit stall, input bit collide, input word_t cw,
                       output int cyc);
      word_t e;
      bit has_dep;
      dep_q = {};
      shd_m = {};
      if (collide) shd_m.push_back(cw);
      foreach (act_m[i]) begin
         if (is_home(act_m[i])) shd_m.push_back(act_m[i]);
         else dep_q.push_back(act_m[i]);
      end
      has_dep = dep_q.size() > 0;
      out_avail = stall ? 1'b0 : 1'b1;
      en = 1'b1;
      cyc = 0;
      while (!done && cyc < 3000) begin
         tick();
         cyc++;
         if (out_valid) begin
            if (dep_q.size() == 0) begin
               chk("extra_departure", 1, 0);
            end else begin
               e = dep_q.pop_front();
               chk("dep_data", out_data, e);
               chk("dep_dest", {dx, dy, dz},
                   {bin_of(e, 0), bin_of(e, 1), bin_of(e, 2)});
            end
         end
         if (stall && has_dep && cyc <= 10) begin
            chk("stall_out_valid", out_valid, 0);
            chk("stall_done", done, 0);
         end
         if (collide && cyc == 2) begin
            in_valid = 1'b1;
            in_data = cw;
            {tx, ty, tz} = '0;
         end
         if (cyc == 3) in_valid = 1'b0;
         if (stall) out_avail = (cyc >= 10) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      out_avail = 1'b1;
      in_valid = 1'b0;
      chk("scan_done", done, 1);
      chk("dep_left", dep_q.size(), 0);
   endtask

   task automatic send_in(input word_t w, input bit v, input logic [BAW-1:0] x,
                          input logic [BAW-1:0] y, input logic [BAW-1:0] z);
      in_valid = v;
      in_data = w;
      tx = x;
      ty = y;
      tz = z;
      #1;
      chk("in_avail", in_avail, shd_m.size() < DEPTH);
      if (v && x == 0 && y == 0 && z == 0 && shd_m.size() < DEPTH)
         shd_m.push_back(w);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic commit();
      en = 1'b0;
      tick();
      act_m = shd_m;
      chk("done_clear", done, 0);
   endtask

   task automatic readback(input int n);
      for (int a = 0; a < n; a++) begin
         rd_addr = AW'(a);
         tick();
         chk("rd_valid", ev_valid, a < act_m.size());
         if (a < act_m.size()) chk("rd_data", ev_data, act_m[a]);
      end
   endtask

   initial begin
      int cyc, n;
      bit home;
      word_t w;
      logic [BAW-1:0] x, y, z;

      repeat (3) tick();
      chk("rst_read_out", ev_data, 0);
      chk("rst_ev_valid", ev_valid, 0);
      chk("rst_in_avail", in_avail, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_data_out", out_data, 0);
      chk("rst_dest", {dx, dy, dz}, 0);
      chk("rst_done", done, 0);
      rst_n = 1'b1;
      for (int a = 0; a < 12; a++) begin
         rd_addr = AW'(a);
         tick();
         chk("empty_valid", ev_valid, 0);
         chk("empty_done", done, 0);
      end

      scan(1'b0, 1'b0, '0, cyc);
      chk("empty_scan_fast", cyc <= 2, 1);
      for (int c = 0; c < 5; c++) send_in(mk_spec(c), 1'b1, 0, 0, 0);
      send_in('0, 1'b1, 0, 0, 0);
      commit();
      readback(12);

      scan(1'b1, 1'b0, '0, cyc);
      for (int k = 1; k <= 5; k++)
         send_in(mk_rand(1'b1), 1'b1, BAW'(k), BAW'(k), BAW'(k));
      send_in(mk_rand(1'b1), 1'b1, 0, 0, 0);
      commit();
      readback(6);

      scan(1'b0, 1'b1, mk_rand(1'b1), cyc);
      commit();
      readback(8);

      for (int it = 0; it < 4; it++) begin
         scan(1'b1, 1'b0, '0, cyc);
         n = $urandom_range(0, 24);
         for (int k = 0; k < n; k++) begin
            home = 1'($urandom_range(0, 1));
            x = home ? '0 : BAW'($urandom_range(0, 15));
            y = home ? '0 : BAW'($urandom_range(0, 15));
            z = home ? '0 : BAW'($urandom_range(0, 15));
            w = mk_rand(1'($urandom_range(0, 1)));
            send_in(w, $urandom_range(0, 3) != 0, x, y, z);
         end
         commit();
         readback(act_m.size() + 2);
      end

      scan(1'b0, 1'b0, '0, cyc);
      for (int k = 0; k < DEPTH + 4; k++)
         send_in(mk_rand(1'($urandom_range(0, 1))), 1'b1, 0, 0, 0);
      commit();
      readback(DEPTH);

      scan(1'b1, 1'b0, '0, cyc);
      commit();
      readback(act_m.size() < DEPTH ? act_m.size() + 1 : DEPTH);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
